// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch (IF) and load/store (D).
// One outstanding transaction at a time; D wins ties unless IF has waited out a full data streak.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    output logic                    if_gnt_o,
    output logic                    if_rvalid_o,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,

    input  logic                    d_req_i,
    input  logic                    d_we_i,
    input  logic [DATA_WIDTH/8-1:0] d_be_i,
    input  logic [ADDR_WIDTH-1:0]   d_addr_i,
    input  logic [DATA_WIDTH-1:0]   d_wdata_i,
    output logic                    d_gnt_o,
    output logic                    d_rvalid_o,
    output logic [DATA_WIDTH-1:0]   d_rdata_o,

    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,

    output logic                    mem_stall_o,
    output logic                    busy_o
);

    // state | meaning
    // IDLE  | no transaction; arbitrate and grant
    // REQ   | mem_req_o held with captured fields until mem_gnt_i
    // WAIT  | request accepted; waiting for mem_rvalid_i
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    localparam int BE_W     = DATA_WIDTH / 8;
    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    logic [1:0]            state;
    logic                  owner_d;
    logic                  we_q;
    logic [BE_W-1:0]       be_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STREAK_W-1:0]   streak;

    logic in_idle;
    logic arb_d;
    logic arb_if;
    logic grant_d;
    logic grant_if;
    logic resp;

    assign in_idle  = (state == IDLE);
    assign arb_d    = d_req_i && !(if_req_i && (streak == STREAK_MAX));
    assign arb_if   = if_req_i && !arb_d;
    assign grant_d  = in_idle && arb_d;
    assign grant_if = in_idle && arb_if;
    assign resp     = (state == WAIT) && mem_rvalid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            owner_d <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            streak  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        owner_d <= 1'b1;
                        we_q    <= d_we_i;
                        be_q    <= d_be_i;
                        addr_q  <= d_addr_i;
                        wdata_q <= d_wdata_i;
                        state   <= REQ;
                        // Streak only grows while IF is actually being held off
                        if (!if_req_i)
                            streak <= '0;
                        else if (streak != STREAK_MAX)
                            streak <= streak + STREAK_W'(1);
                    end else if (grant_if) begin
                        owner_d <= 1'b0;
                        we_q    <= 1'b0;
                        be_q    <= '1;
                        addr_q  <= if_addr_i;
                        wdata_q <= '0;
                        state   <= REQ;
                        streak  <= '0;
                    end
                end
                REQ:     if (mem_gnt_i) state <= WAIT;
                WAIT:    if (mem_rvalid_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Grants are combinational on the request, so mask them while reset is held
    assign if_gnt_o    = grant_if && !rst_i;
    assign d_gnt_o     = grant_d && !rst_i;

    assign if_rvalid_o = resp && !owner_d;
    assign d_rvalid_o  = resp && owner_d;
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;

    assign mem_req_o   = (state == REQ);
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    assign mem_stall_o = !rst_i &&
                         ((d_req_i && !d_gnt_o) ||
                          (owner_d && (state == REQ || state == WAIT) && !resp));
    assign busy_o      = !in_idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, stalled store, contention, reset abort,
// back-to-back loads and spurious responses, all with hand-computed expectations.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_gnt_o;
    logic          if_rvalid_o;
    logic [DW-1:0] if_rdata_o;
    logic          d_req_i;
    logic          d_we_i;
    logic [3:0]    d_be_i;
    logic [AW-1:0] d_addr_i;
    logic [DW-1:0] d_wdata_i;
    logic          d_gnt_o;
    logic          d_rvalid_o;
    logic [DW-1:0] d_rdata_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [3:0]    mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_stall_o;
    logic          busy_o;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DATA_STREAK(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
        .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .mem_stall_o(mem_stall_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [9:0] exp_order;
        int         n_gnt;

        rst_i = 1'b1;
        if_req_i = 1'b1; if_addr_i = 32'h0;
        d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'h0; d_addr_i = 32'h0; d_wdata_i = 32'h0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;

        // Outputs quiet during reset even with both requests up
        @(negedge clk_i);
        chk("rst_gnts", {if_gnt_o, d_gnt_o}, 0);
        chk("rst_stall_busy_req", {mem_stall_o, busy_o, mem_req_o}, 0);
        chk("rst_rvalid", {if_rvalid_o, d_rvalid_o}, 0);
        tick();
        rst_i = 1'b0; if_req_i = 1'b0; d_req_i = 1'b0;

        // Single fetch, zero-wait memory
        if_req_i = 1'b1; if_addr_i = 32'h100;
        @(negedge clk_i);
        chk("fetch_gnt", {if_gnt_o, d_gnt_o, mem_stall_o, busy_o}, 4'b1000);
        tick();
        if_req_i = 1'b0; mem_gnt_i = 1'b1;
        @(negedge clk_i);
        chk("fetch_req", {mem_req_o, mem_we_o, mem_be_o, mem_stall_o}, 7'b1011110);
        chk("fetch_addr", mem_addr_o, 32'h100);
        chk("fetch_wdata", mem_wdata_o, 0);
        tick();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        @(negedge clk_i);
        chk("fetch_rvalid", {if_rvalid_o, d_rvalid_o, mem_req_o, mem_stall_o}, 4'b1000);
        chk("fetch_rdata", if_rdata_o, 32'hDEADBEEF);
        chk("fetch_d_rdata_zero", d_rdata_o, 0);
        tick();
        mem_rvalid_i = 1'b0;

        // Spurious response in IDLE
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h99;
        @(negedge clk_i);
        chk("spur_idle", {if_rvalid_o, d_rvalid_o, busy_o, if_rdata_o}, 0);
        tick();
        mem_rvalid_i = 1'b0;
        @(negedge clk_i);
        chk("spur_idle_after", busy_o, 0);

        // Store with mem_gnt_i delayed three cycles, spurious rvalid during REQ
        tick();
        d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'h3; d_addr_i = 32'h40; d_wdata_i = 32'h1234;
        @(negedge clk_i);
        chk("st_gnt", {d_gnt_o, if_gnt_o, mem_stall_o}, 3'b100);
        tick();
        d_req_i = 1'b0; d_addr_i = 32'hFFFF; d_wdata_i = 32'hFFFF; d_be_i = 4'hC;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid_i = (i == 0);
            mem_gnt_i    = (i == 3);
            @(negedge clk_i);
            chk("st_req_ctl", {mem_req_o, mem_we_o, mem_be_o, mem_stall_o, busy_o}, 8'b11001111);
            chk("st_req_fields", {mem_addr_o, mem_wdata_o}, {32'h40, 32'h1234});
            chk("st_req_no_rvalid", {d_rvalid_o, if_rvalid_o}, 0);
            tick();
        end
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        @(negedge clk_i);
        chk("st_wait", {mem_req_o, mem_stall_o, d_rvalid_o}, 3'b010);
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55;
        @(negedge clk_i);
        chk("st_ack", {d_rvalid_o, if_rvalid_o, mem_stall_o}, 3'b100);
        chk("st_ack_rdata", {d_rdata_o, if_rdata_o}, {32'h55, 32'h0});
        tick();
        mem_rvalid_i = 1'b0; d_we_i = 1'b0; d_be_i = 4'hF;
        @(negedge clk_i);
        chk("st_done", {mem_stall_o, busy_o}, 0);
        tick();

        // Contention: both requesters held, zero-wait memory
        if_req_i = 1'b1; if_addr_i = 32'h180;
        d_req_i = 1'b1; d_addr_i = 32'h80;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0;
        exp_order = 10'b0111101111;
        n_gnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_i);
            chk("cont_one_gnt", {if_gnt_o && d_gnt_o}, 0);
            if (if_gnt_o || d_gnt_o) begin
                if (n_gnt < 10) chk($sformatf("cont_order%0d", n_gnt), d_gnt_o, exp_order[n_gnt]);
                n_gnt++;
            end
            tick();
        end
        chk("cont_count", n_gnt, 10);
        if_req_i = 1'b0; d_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;

        // Reset while in WAIT, then a late response
        if_req_i = 1'b1; if_addr_i = 32'h200;
        @(negedge clk_i);
        chk("rm_gnt", if_gnt_o, 1);
        tick();
        if_req_i = 1'b0; mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        @(negedge clk_i);
        chk("rm_wait_busy", {busy_o, mem_req_o}, 2'b10);
        #1 rst_i = 1'b1;
        #1;
        chk("rm_reset_now", {busy_o, mem_req_o, mem_addr_o}, 0);
        tick();
        rst_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD;
        @(negedge clk_i);
        chk("rm_late_resp", {if_rvalid_o, d_rvalid_o, busy_o}, 0);
        tick();
        mem_rvalid_i = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h300;
        @(negedge clk_i);
        chk("rm_next_gnt", {if_gnt_o, d_gnt_o}, 2'b10);
        tick();
        if_req_i = 1'b0; mem_gnt_i = 1'b1;
        @(negedge clk_i);
        chk("rm_next_req", {mem_req_o, mem_addr_o}, {1'b1, 32'h300});
        tick();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77;
        @(negedge clk_i);
        chk("rm_next_rdata", {if_rvalid_o, if_rdata_o}, {1'b1, 32'h77});
        tick();
        mem_rvalid_i = 1'b0;

        // Back-to-back loads, zero-wait memory
        d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'hF; d_addr_i = 32'h10;
        @(negedge clk_i);
        chk("bb_gnt1", d_gnt_o, 1);
        tick();
        d_addr_i = 32'h14; mem_gnt_i = 1'b1;
        @(negedge clk_i);
        chk("bb_req1", {d_gnt_o, mem_req_o, mem_stall_o, mem_addr_o}, {3'b011, 32'h10});
        tick();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA;
        @(negedge clk_i);
        chk("bb_resp1", {d_rvalid_o, d_gnt_o, d_rdata_o}, {2'b10, 32'hA});
        tick();
        mem_rvalid_i = 1'b0;
        @(negedge clk_i);
        chk("bb_gnt2", {d_gnt_o, mem_stall_o, busy_o}, 3'b100);
        tick();
        d_req_i = 1'b0; mem_gnt_i = 1'b1;
        @(negedge clk_i);
        chk("bb_req2", {mem_req_o, mem_addr_o}, {1'b1, 32'h14});
        tick();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hB;
        @(negedge clk_i);
        chk("bb_resp2", {d_rvalid_o, d_rdata_o}, {1'b1, 32'hB});
        tick();
        mem_rvalid_i = 1'b0;
        @(negedge clk_i);
        chk("bb_idle", {busy_o, mem_stall_o, d_rvalid_o}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between the instruction-fetch requester (IF) and the load/store requester (D) of the multi-cycle core.
- Only one transaction is outstanding at a time; writes and reads are both completed by a memory response.
- Generates mem_stall_o, which freezes the decode/execute pipeline registers while a data access is unresolved.
- D has priority over IF; a streak limiter prevents IF starvation.

Parameters:
- ADDR_WIDTH, params_pkg::ADDR_WIDTH, byte address width.
- DATA_WIDTH, params_pkg::DATA_WIDTH, data width; byte-enable width BE_W = DATA_WIDTH/8.
- MAX_DATA_STREAK, 4, consecutive D grants allowed while IF waits; legal range >= 1; counter width $clog2(MAX_DATA_STREAK+1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. Asynchronous, active-high.
- if_req_i  in  1  fetch request; held with if_addr_i until if_gnt_o.
- if_addr_i  in  ADDR_WIDTH  fetch address.
- if_gnt_o  out  1  fetch request accepted this cycle.
- if_rvalid_o  out  1  fetch data valid.
- if_rdata_o  out  DATA_WIDTH  fetch data.
- d_req_i  in  1  load/store request; held with its fields until d_gnt_o.
- d_we_i  in  1  1 = store.
- d_be_i  in  BE_W  byte enables.
- d_addr_i  in  ADDR_WIDTH  data address.
- d_wdata_i  in  DATA_WIDTH  store data.
- d_gnt_o  out  1  data request accepted this cycle.
- d_rvalid_o  out  1  load data valid / store acknowledged.
- d_rdata_o  out  DATA_WIDTH  load data.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  BE_W  memory byte enables.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_wdata_o  out  DATA_WIDTH  memory write data.
- mem_gnt_i  in  1  memory accepted the request.
- mem_rvalid_i  in  1  memory response valid.
- mem_rdata_i  in  DATA_WIDTH  memory read data.
- mem_stall_o  out  1  pipeline stall for an unresolved data access.
- busy_o  out  1  state != IDLE.

Behaviour:
- FSM states: IDLE, REQ, WAIT. Registered fields: owner (IF/D), we, be, addr, wdata, streak counter.
- Reset: asynchronous assertion forces IDLE, owner=IF, all registered fields to 0 and streak=0, so mem_req_o deasserts immediately. All outputs are 0 during reset.
- IDLE arbitration: winner = D if d_req_i, unless (if_req_i && streak == MAX_DATA_STREAK), in which case winner = IF. Otherwise winner = IF if if_req_i.
- On a winner in IDLE:
  - Pulse the winner's gnt_o combinationally that cycle.
  - Capture its fields into the registers (IF capture: we=0, be=all-ones, wdata=0).
  - Go to REQ.
- Streak counter, updated at each IDLE grant:
  - D granted while if_req_i=1: streak++ (saturates at MAX_DATA_STREAK).
  - IF granted, or D granted with if_req_i=0: streak = 0.
- REQ: mem_req_o=1; mem_we/be/addr/wdata driven from registers and stable. On mem_gnt_i go to WAIT; otherwise stay.
- WAIT: mem_req_o=0. When mem_rvalid_i=1, assert the owner's rvalid_o for that one cycle, forward mem_rdata_i unregistered on that requester's rdata_o, and return to IDLE.
- The returning IDLE cycle may arbitrate and grant immediately. Best case is 2 cycles from grant to rvalid: grant in cycle N, mem_gnt_i in N+1, mem_rvalid_i in N+2.
- mem_rvalid_i outside WAIT is ignored, including a late response after reset.
- rdata_o of the non-owner is 0. The rdata_o of the owner is 0 when rvalid is low.
- mem_stall_o = (d_req_i && !d_gnt_o) || (owner==D && state in {REQ, WAIT} && !(state==WAIT && mem_rvalid_i)). This is combinational.
- Simultaneous requests in IDLE: exactly one gnt_o is asserted. The loser must keep its req asserted.
- A requester that drops req before gnt is never granted. No transaction is created for it.
- No new grant is issued while state != IDLE.

Test Plan:
- Single fetch: if_req_i=1 with addr 0x100; memory gnt after 0 waits, rvalid 1 cycle later with 0xDEADBEEF -> if_gnt_o in cycle 0, mem_req_o in cycle 1, if_rvalid_o=1 with 0xDEADBEEF in cycle 2, mem_stall_o=0 throughout.
- Store with a memory stall: d_req_i with we=1, be=0x3, addr 0x40, wdata 0x1234; mem_gnt_i delayed 3 cycles -> mem fields held stable during REQ, mem_stall_o=1 from request until the d_rvalid_o cycle, then 0.
- Contention: if_req_i and d_req_i both held continuously, MAX_DATA_STREAK=4 -> grant order D,D,D,D,IF,D,D,D,D,IF; never two gnts in one cycle.
- Reset mid-transaction: assert rst_i while in WAIT, then deliver mem_rvalid_i after release -> mem_req_o and busy_o are 0 immediately; no rvalid_o is produced; the next if_req_i is granted normally.
- Back-to-back loads with zero-wait memory: two D loads -> second d_gnt_o in the same cycle as the first d_rvalid_o's return to IDLE; the responses (0xA, 0xB) are delivered in order.
- Spurious mem_rvalid_i in IDLE or REQ -> no rvalid_o and no state change.
